counter_sweep_ctrl: RTL
=======================

Name: counter_sweep_ctrl

Overview:
Sequencer that drives the team's 8-bit up/down counter (ports rst, enable, direction, counter_out) through a programmed ping-pong sweep between a low and a high limit for N passes. It issues the counter's reset, enable and direction each cycle, monitors counter_out, and reports busy, done and error to a host. It sits between a host/config register block and the counter instance.

Parameters:
WIDTH, 8, counter and limit width (matches counter_out)
PASS_W, 4, width of the pass-count configuration and status

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  terminate a running sweep
lo  input  WIDTH  low sweep limit; latched on accepted start
hi  input  WIDTH  high sweep limit; latched on accepted start
passes  input  PASS_W  number of full up+down passes; latched on accepted start
counter_out  input  WIDTH  current value from the counter
ctr_rst  output  1  reset to the counter (combinational, state-decoded)
ctr_enable  output  1  enable to the counter (combinational)
ctr_direction  output  1  1 = count up, 0 = count down (combinational)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on rejected config or counter fault
pass_cnt  output  PASS_W  completed passes in the current or last sweep

Behaviour:
- Reset: state = IDLE, pass_cnt = 0, latched config = 0. Outputs ctr_rst, ctr_enable, ctr_direction, busy, done and err are all 0. rst overrides every other input, including mid-sweep.
- Counter contract: the counter clears on ctr_rst. It +1 on enable&direction, -1 on enable&!direction, and holds when enable = 0. All updates take effect at the next edge.
- States: IDLE, CLEAR, SEEK, UP, DOWN, DONE.
- IDLE: all counter controls 0. start=1 latches lo, hi and passes.
  - Reject (lo >= hi or passes == 0): err = 1 next cycle, stay IDLE.
  - Accept: clear pass_cnt, go to CLEAR.
- CLEAR (1 cycle): ctr_rst = 1, ctr_enable = 0. Go to SEEK.
- SEEK: ctr_direction = 1, ctr_enable = (counter_out != lo).
  - counter_out == lo: go to UP.
  - counter_out > lo: fault.
- UP: ctr_direction = 1, ctr_enable = (counter_out != hi).
  - counter_out == hi: go to DOWN. The counter holds one cycle at hi.
  - counter_out outside [lo,hi]: fault.
- DOWN: ctr_direction = 0, ctr_enable = (counter_out != lo).
  - counter_out == lo: pass_cnt += 1. The counter holds one cycle at lo.
    - New pass_cnt == passes: go to DONE.
    - Otherwise: go to UP.
  - counter_out outside [lo,hi]: fault.
- DONE (1 cycle): done = 1, busy = 0, controls 0. Go to IDLE.
- Fault: err = 1 next cycle, go to IDLE, pass_cnt holds; done is not asserted.
- abort in CLEAR/SEEK/UP/DOWN: ctr_enable is forced to 0 that cycle, next state IDLE. No done, no err; pass_cnt holds. abort in IDLE/DONE is ignored.
- Priority (highest first): rst, abort, fault, normal transition.
- start while busy is ignored; the latched config does not change.
- lo == 0 is legal: SEEK lasts one cycle.
- Latency, cycles from the start-sampling edge to the done-high cycle: 2 + (lo+1) + passes*2*(hi-lo+1).
- busy is high in CLEAR, SEEK, UP and DOWN.
- Outputs on the done/err cycle:
  - done and err are registered. Each is high exactly one cycle and never high together.
  - pass_cnt is registered and stays valid after done.

Test Plan:
- Reset: hold rst 3 cycles mid-sweep (UP, counter_out = 4) -> next cycle IDLE, all outputs 0, pass_cnt = 0; a counter_out change does not affect state.
- Basic sweep: lo=2, hi=5, passes=1, start 1 cycle -> ctr_rst high cycle 1. Counter sequence 0,1,2,2,3,4,5,5,4,3,2,2. done high exactly at cycle 13, busy low from cycle 13, pass_cnt = 1.
- Multi-pass with lo=0: lo=0, hi=3, passes=3 -> counter 0 → 3 → 0 three times. pass_cnt steps 1,2,3, done at cycle 2+1+3*8 = 27, counter never leaves [0,3].
- Config reject: lo=5, hi=5, passes=2 -> err pulse 1 cycle, busy never high, ctr_rst never asserted. Repeat with passes=0 -> same.
- Abort and ignored start: during DOWN of pass 2 (lo=1, hi=4, passes=4), assert abort -> ctr_enable 0 that cycle, IDLE next, no done/err, pass_cnt = 1. Separately, start pulses while busy -> no restart, latency unchanged.
- Counter fault: in UP with hi=6, force counter_out to 9 -> err pulse next cycle, IDLE, done never asserted.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// Ping-pong sweep sequencer for an external up/down counter: drives reset/enable/direction
// between latched lo/hi limits for a programmed number of passes, reporting busy/done/err.
module counter_sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  counter_out,
  output logic              ctr_rst,
  output logic              ctr_enable,
  output logic              ctr_direction,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEEK,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [PASS_W-1:0] r_passes;
  logic [PASS_W-1:0] r_pass_cnt;
  logic              r_done;
  logic              r_err;

  logic              w_reject;
  logic              w_in_range;
  logic              w_busy;
  logic              w_fault;
  logic              w_err_set;
  logic              w_clr_cnt;
  logic              w_inc_cnt;
  logic [PASS_W-1:0] w_pass_nxt;

  assign w_reject   = (lo >= hi) || (passes == '0);
  assign w_in_range = (counter_out >= r_lo) && (counter_out <= r_hi);
  assign w_busy     = (r_state == S_CLEAR) || (r_state == S_SEEK) ||
                      (r_state == S_UP)    || (r_state == S_DOWN);
  assign w_pass_nxt = r_pass_cnt + PASS_W'(1);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    ctr_rst       = 1'b0;
    ctr_enable    = 1'b0;
    ctr_direction = 1'b0;
    w_fault       = 1'b0;
    w_err_set     = 1'b0;
    w_clr_cnt     = 1'b0;
    w_inc_cnt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_reject) begin
            w_err_set = 1'b1;
          end else begin
            w_clr_cnt = 1'b1;
            w_next    = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        ctr_rst = 1'b1;
        w_next  = S_SEEK;
      end
      S_SEEK: begin
        ctr_direction = 1'b1;
        ctr_enable    = (counter_out != r_lo);
        if (counter_out == r_lo)     w_next  = S_UP;
        else if (counter_out > r_lo) w_fault = 1'b1;
      end
      S_UP: begin
        ctr_direction = 1'b1;
        ctr_enable    = (counter_out != r_hi);
        if (!w_in_range)             w_fault = 1'b1;
        else if (counter_out == r_hi) w_next = S_DOWN;
      end
      S_DOWN: begin
        ctr_enable = (counter_out != r_lo);
        if (!w_in_range) begin
          w_fault = 1'b1;
        end else if (counter_out == r_lo) begin
          w_inc_cnt = 1'b1;
          w_next    = (w_pass_nxt == r_passes) ? S_DONE : S_UP;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (w_fault) w_next = S_IDLE;

    // Abort outranks a fault in the same cycle: the sweep just stops quietly.
    if (abort && w_busy) begin
      ctr_enable = 1'b0;
      w_fault    = 1'b0;
      w_inc_cnt  = 1'b0;
      w_next     = S_IDLE;
    end

    if (w_fault) w_err_set = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_hi       <= '0;
      r_passes   <= '0;
      r_pass_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_lo     <= lo;
        r_hi     <= hi;
        r_passes <= passes;
      end
      if (w_clr_cnt)      r_pass_cnt <= '0;
      else if (w_inc_cnt) r_pass_cnt <= w_pass_nxt;
      r_done <= (w_next == S_DONE);
      r_err  <= w_err_set;
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign pass_cnt = r_pass_cnt;

endmodule
